// File: rtl/adder_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter_if
//  Purpose  : Bundles the requester operand handshake and the shared result
//             handshake of adder_arbiter into one port.
//  Signals  : req_valid/req_ready  per-requester operand handshake
//             req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//             res_valid/res_ready  result handshake
//             res_sum/res_id       registered sum and winning requester index
//  Modports : slave  - the arbiter
//             master - requesters and result consumer
//  Config   : ADDER_ARB_CARRY_EN widens res_sum by one bit to keep the carry.
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int IDW = $clog2(NUM_REQ);
`ifdef ADDER_ARB_CARRY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [RW-1:0]            res_sum;
  logic [IDW-1:0]           res_id;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id
  );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Purpose  : Round-robin arbiter sharing one nibble adder among NUM_REQ
//             requesters. One operand pair is granted per cycle; its sum and
//             requester index land in a one-entry output register.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - adder_arbiter_if.slave (operand and result handshakes)
//  Config   : ADDER_ARB_CARRY_EN defined -> res_sum is WIDTH+1 bits (carry
//             kept); undefined -> res_sum is WIDTH bits, wraps mod 2^WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  adder_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(NUM_REQ);
`ifdef ADDER_ARB_CARRY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     cand;
  logic               found;
  logic               can_accept;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH-1:0]   a_g;
  logic [WIDTH-1:0]   b_g;
  logic [RW-1:0]      sum;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The slot can take a new result when empty or being drained this cycle.
  assign can_accept = !bus.res_valid || bus.res_ready;
  // Reset suppresses every grant for the whole reset cycle.
  assign accept     = !rst && can_accept && found;
  assign ready      = accept ? (NUM_REQ'(1) << winner) : '0;
  assign bus.req_ready = ready;

  // Operand mux over constant slices keeps the select free of variable part-selects.
  always_comb begin
    a_g = '0;
    b_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        a_g = bus.req_a[i*WIDTH +: WIDTH];
        b_g = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Operands are zero-extended to RW so the carry survives only when RW > WIDTH.
  assign sum = RW'(a_g) + RW'(b_g);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_id    <= '0;
      ptr           <= '0;
    end else if (accept) begin
      // Covers both a fresh fill and drain-plus-refill: no bubble.
      bus.res_valid <= 1'b1;
      bus.res_sum   <= sum;
      bus.res_id    <= winner;
      ptr           <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Purpose  : Scoreboard bench for adder_arbiter. A reference model predicts
//             grants and sums from the arbitration rules; a monitor checks
//             every presented result against the expected queue.
//  Config   : honours ADDER_ARB_CARRY_EN for the result width.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
`ifdef ADDER_ARB_CARRY_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  adder_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int id;
    int sum;
  } exp_t;

  exp_t               q[$];
  int                 total = 0;
  int                 bad   = 0;
  int                 ptr_m = 0;
  bit                 slot_m = 1'b0;
  logic [NUM_REQ-1:0] held = '0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Reference model: pick the first valid requester at or after the rotating
  // pointer, predict ready, and queue the expected sum for an accepted pair.
  task automatic model_eval();
    bit                 found;
    bit                 can;
    int                 g;
    int                 a;
    int                 b;
    logic [NUM_REQ-1:0] er;
    found = 1'b0;
    g     = 0;
    can   = !slot_m || bus.res_ready;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (ptr_m + k) % NUM_REQ;
      if (!found && bus.req_valid[i]) begin
        found = 1'b1;
        g     = i;
      end
    end
    er = (!rst && can && found) ? (NUM_REQ'(1) << g) : '0;
    check("req_ready", int'(bus.req_ready), int'(er));
    check("res_valid", int'(bus.res_valid), int'(slot_m));
    if (rst) begin
      slot_m = 1'b0;
      ptr_m  = 0;
      q.delete();
    end else if (er != '0) begin
      a = int'(bus.req_a[g*WIDTH +: WIDTH]);
      b = int'(bus.req_b[g*WIDTH +: WIDTH]);
      q.push_back('{id: g, sum: (a + b) % (1 << RW)});
      slot_m = 1'b1;
      ptr_m  = (g + 1) % NUM_REQ;
    end else if (slot_m && bus.res_ready) begin
      slot_m = 1'b0;
    end
    held = bus.req_valid & ~er;
  endtask

  // One clock of stimulus. Requesters left waiting keep their valid and
  // operands; the others take vmask and fresh (or fixed) operands.
  task automatic step(input logic [NUM_REQ-1:0] vmask, input bit rdy, input bit rs,
                      input int fa, input int fb);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!held[i]) begin
        bus.req_valid[i] = vmask[i];
        bus.req_a[i*WIDTH +: WIDTH] = (fa >= 0) ? WIDTH'(fa) : WIDTH'($urandom);
        bus.req_b[i*WIDTH +: WIDTH] = (fb >= 0) ? WIDTH'(fb) : WIDTH'($urandom);
      end
    end
    bus.res_ready = rdy;
    rst = rs;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a result is presented it must match the queue head,
  // and stay matching through stalls; it is retired on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.res_valid) begin
        if (q.size() == 0) begin
          check("res_unexpected", int'(bus.res_valid), 0);
        end else begin
          check("res_id", int'(bus.res_id), q[0].id);
          check("res_sum", int'(bus.res_sum), q[0].sum);
          if (bus.res_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with everyone requesting, then first grant to requester 0.
    step(4'b1111, 1'b1, 1'b1, -1, -1);
    step(4'b1111, 1'b1, 1'b1, -1, -1);
    check("rst_sum", int'(bus.res_sum), 0);
    check("rst_id", int'(bus.res_id), 0);
    step(4'b1111, 1'b1, 1'b0, -1, -1);
    repeat (4) step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Single request from requester 2: 3 + 5.
    step(4'b0100, 1'b1, 1'b0, 3, 5);
    repeat (2) step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Round-robin from a fresh pointer.
    step(4'b0000, 1'b1, 1'b1, -1, -1);
    repeat (8) step(4'b1111, 1'b1, 1'b0, -1, -1);
    repeat (4) step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Sparse requesters 1 and 3.
    repeat (4) step(4'b1010, 1'b1, 1'b0, -1, -1);
    repeat (3) step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Backpressure: id 1 with sum 0xA held for 3 cycles, then drain+accept.
    step(4'b0000, 1'b1, 1'b1, -1, -1);
    step(4'b0010, 1'b1, 1'b0, 4, 6);
    repeat (3) step(4'b0001, 1'b0, 1'b0, -1, -1);
    step(4'b0001, 1'b1, 1'b0, -1, -1);
    repeat (3) step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Overflow, then reset while the result is stalled.
    step(4'b0001, 1'b1, 1'b0, 15, 1);
    step(4'b0000, 1'b0, 1'b0, -1, -1);
    step(4'b0000, 1'b0, 1'b1, -1, -1);
    step(4'b0000, 1'b1, 1'b0, -1, -1);

    // Randomized traffic with backpressure and occasional reset.
    for (int n = 0; n < 400; n++) begin
      step(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0), -1, -1);
    end

    // Drain everything still pending.
    repeat (8) step(4'b0000, 1'b1, 1'b0, -1, -1);
    check("drain_queue", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
